// File: rtl/gate_op_pkg.sv
// Shared types for the gate operation sequencer: FSM states, selector codes
// and the reference function for what the downstream gate should output.
package gate_op_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_00 = 2'b00;
  localparam logic [1:0] SEL_01 = 2'b01;
  localparam logic [1:0] SEL_10 = 2'b10;
  localparam logic [1:0] SEL_11 = 2'b11;

  // Only SEL_11 turns the gate into an XNOR; every other code behaves as XOR.
  function automatic logic expected_y(input logic [1:0] mode, input logic a,
                                      input logic b);
    logic y;
    case (mode)
      SEL_00, SEL_01, SEL_10: y = a ^ b;
      SEL_11:                 y = ~(a ^ b);
      default:                y = a ^ b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gate_op_sequencer.sv
// Drives one operand/selector set into an external gate, waits a fixed settle
// time, captures and checks Y, and hands the result back over a ready/valid port.
module gate_op_sequencer
  import gate_op_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             VPWR,
  input  logic             VGND,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_a,
  input  logic             cmd_b,
  output logic             A,
  output logic             B,
  output logic [1:0]       input_state,
  input  logic             Y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_y,
  output logic             rsp_err,
  output logic             rsp_pwr_fail,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic       ready_q;
  logic [3:0] settle_q;
  logic       a_q;
  logic       b_q;
  logic [1:0] sel_q;
  logic       rsp_valid_q;
  logic       rsp_y_q;
  logic       rsp_err_q;
  logic       rsp_pwr_fail_q;

  logic pwr_good;
  logic accept;
  logic y_bad;
  logic y_exp;
  logic rsp_hs;

  assign pwr_good = VPWR & ~VGND;
  // ready_q only says "an edge has been seen in IDLE with power good"; the live
  // pwr_good term withdraws readiness the moment the rail drops.
  assign cmd_ready = ready_q & pwr_good & (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign y_exp     = expected_y(sel_q, a_q, b_q);
  assign y_bad     = (Y !== 1'b0) && (Y !== 1'b1);
  assign rsp_hs    = (state_q == RESP) & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ready_q        <= 1'b0;
      settle_q       <= '0;
      a_q            <= 1'b0;
      b_q            <= 1'b0;
      sel_q          <= SEL_00;
      rsp_valid_q    <= 1'b0;
      rsp_y_q        <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_pwr_fail_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= pwr_good;
          if (accept) begin
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            sel_q    <= cmd_mode;
            settle_q <= SETTLE_INIT;
            ready_q  <= 1'b0;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          if (!pwr_good) begin
            rsp_valid_q    <= 1'b1;
            rsp_y_q        <= 1'b0;
            rsp_err_q      <= 1'b1;
            rsp_pwr_fail_q <= 1'b1;
            settle_q       <= '0;
            state_q        <= RESP;
          end else if (settle_q == '0) begin
            rsp_valid_q    <= 1'b1;
            rsp_y_q        <= Y;
            rsp_err_q      <= y_bad | (Y != y_exp);
            rsp_pwr_fail_q <= 1'b0;
            state_q        <= RESP;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        RESP: begin
          // Returning to IDLE here keeps cmd_ready low for this whole cycle,
          // so a new command can only land on the following edge.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= pwr_good;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign input_state  = sel_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_pwr_fail = rsp_pwr_fail_q;

  sat_counter #(.W(CNT_W)) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_cnt),
    .inc_i (rsp_hs),
    .cnt_o (op_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_cnt),
    .inc_i (rsp_hs & rsp_err_q),
    .cnt_o (err_count)
  );

endmodule

// File: tb/tb_gate_op_sequencer.sv
// Directed bench for gate_op_sequencer with a behavioural xnor_gate model and
// a scoreboard queue of expected responses.
module tb_gate_op_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned CW     = 2;

  typedef struct packed {
    logic y;
    logic err;
    logic pwr;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          VPWR;
  logic          VGND;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic          cmd_a;
  logic          cmd_b;
  logic          A;
  logic          B;
  logic [1:0]    input_state;
  logic          Y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_y;
  logic          rsp_err;
  logic          rsp_pwr_fail;
  logic          clr_cnt;
  logic [CW-1:0] op_count;
  logic [CW-1:0] err_count;

  logic y_force;
  logic y_force_val;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  gate_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .VPWR         (VPWR),
    .VGND         (VGND),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .A            (A),
    .B            (B),
    .input_state  (input_state),
    .Y            (Y),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_err      (rsp_err),
    .rsp_pwr_fail (rsp_pwr_fail),
    .clr_cnt      (clr_cnt),
    .op_count     (op_count),
    .err_count    (err_count)
  );

  // Downstream gate: XNOR when selector is 11, XOR otherwise, optionally overridden.
  assign Y = y_force ? y_force_val
                     : ((input_state == 2'b11) ? ~(A ^ B) : (A ^ B));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_y"},     32'(rsp_y), 32'(e.y));
    check({tag, "_err"},   32'(rsp_err), 32'(e.err));
    check({tag, "_pwr"},   32'(rsp_pwr_fail), 32'(e.pwr));
  endtask

  task automatic handshake(input logic clr);
    rsp_ready = 1'b1;
    clr_cnt   = clr;
    tick();
    rsp_ready = 1'b0;
    clr_cnt   = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic push_exp(input logic [1:0] mode, input logic a, input logic b,
                          input logic fen, input logic fval);
    exp_t e;
    logic m;
    m     = (mode == 2'b11) ? ~(a ^ b) : (a ^ b);
    e.y   = fen ? fval : m;
    e.err = (e.y != m);
    e.pwr = 1'b0;
    sb.push_back(e);
  endtask

  task automatic do_op(input string tag, input logic [1:0] mode, input logic a,
                       input logic b, input logic fen, input logic fval,
                       input logic clr);
    int lat;
    y_force     = fen;
    y_force_val = fval;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_a     = a;
    cmd_b     = b;
    push_exp(mode, a, b, fen, fval);
    tick();
    cmd_valid = 1'b0;
    check({tag, "_drive"}, {29'd0, A, B, input_state}, {29'd0, a, b, mode});
    wait_rsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(SETTLE));
    check_rsp(tag);
    handshake(clr);
    y_force = 1'b0;
  endtask

  initial begin
    exp_t pf;
    exp_t held;
    int   lat;

    rst_n       = 1'b0;
    VPWR        = 1'b1;
    VGND        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_mode    = 2'b00;
    cmd_a       = 1'b0;
    cmd_b       = 1'b0;
    rsp_ready   = 1'b0;
    clr_cnt     = 1'b0;
    y_force     = 1'b0;
    y_force_val = 1'b0;
    repeat (2) tick();

    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_y, rsp_err}, 32'd0);
    check("rst_pwr_fail", 32'(rsp_pwr_fail), 32'd0);
    check("rst_drive", {29'd0, A, B, input_state}, 32'd0);
    check("rst_counts", {28'd0, op_count, err_count}, 32'd0);

    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();
    check("ready_after_edge", 32'(cmd_ready), 32'd1);

    do_op("xor_10", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cnt_op1", 32'(op_count), 32'd1);
    check("cnt_err1", 32'(err_count), 32'd0);

    do_op("xnor_11", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cnt_op2", 32'(op_count), 32'd2);

    do_op("xnor_bad", 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("cnt_op3", 32'(op_count), 32'd3);
    check("cnt_err3", 32'(err_count), 32'd1);

    // Back-pressure: response held while a new command waits.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_a     = 1'b0;
    cmd_b     = 1'b1;
    push_exp(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    cmd_mode = 2'b10;
    cmd_a    = 1'b1;
    cmd_b    = 1'b1;
    wait_rsp(lat);
    held = sb[0];
    check_rsp("stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_y_err", {30'd0, rsp_y, rsp_err}, {30'd0, held.y, held.err});
      check("stall_ready", 32'(cmd_ready), 32'd0);
      check("stall_drive", {29'd0, A, B, input_state}, {29'd0, 1'b0, 1'b1, 2'b01});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs_no_accept", {29'd0, A, B, input_state}, {29'd0, 1'b0, 1'b1, 2'b01});
    check("hs_valid_drop", 32'(rsp_valid), 32'd0);
    check("hs_ready_next", 32'(cmd_ready), 32'd1);
    push_exp(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("next_accept", {29'd0, A, B, input_state}, {29'd0, 1'b1, 1'b1, 2'b10});
    wait_rsp(lat);
    check("next_latency", 32'(lat), 32'(SETTLE));
    check_rsp("next");
    handshake(1'b0);

    // Power loss on the first DRIVE cycle.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    cmd_a     = 1'b1;
    cmd_b     = 1'b0;
    pf.y      = 1'b0;
    pf.err    = 1'b1;
    pf.pwr    = 1'b1;
    sb.push_back(pf);
    tick();
    cmd_valid = 1'b0;
    VPWR      = 1'b0;
    tick();
    check_rsp("pwrfail");
    handshake(1'b0);
    check("pwr_idle_ready0", 32'(cmd_ready), 32'd0);
    tick();
    check("pwr_idle_ready1", 32'(cmd_ready), 32'd0);
    VPWR = 1'b1;
    tick();
    check("pwr_restored", 32'(cmd_ready), 32'd1);

    // Saturation at CNT_W=2, then clear wins over the 5th increment.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_counts", {28'd0, op_count, err_count}, 32'd0);
    do_op("sat1", 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sat1_op", 32'(op_count), 32'd1);
    do_op("sat2", 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    do_op("sat3", 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op("sat4", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sat4_op", 32'(op_count), 32'd3);
    check("sat4_err", 32'(err_count), 32'd3);
    do_op("sat5", 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sat5_cleared", {28'd0, op_count, err_count}, 32'd0);

    // Asynchronous reset in the middle of DRIVE.
    do_op("pre_rst", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b11;
    cmd_a     = 1'b1;
    cmd_b     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(cmd_ready), 32'd0);
    check("arst_rsp", {28'd0, rsp_valid, rsp_y, rsp_err, rsp_pwr_fail}, 32'd0);
    check("arst_drive", {29'd0, A, B, input_state}, 32'd0);
    check("arst_counts", {28'd0, op_count, err_count}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_op("recover", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("recover_op", 32'(op_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_op_sequencer.md
GATE_OP_SEQUENCER -- requirements
Module: gate_op_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of clocks between driving gate inputs and sampling Y; legal range 1..15.
REQ-002 Parameter CNT_W, default 8, is the width of the statistics counters.
REQ-003 clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 VPWR  in  1  supply rail; power is good when VPWR==1 and VGND==0 (pwr_good).
REQ-006 VGND  in  1  ground rail.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  command accepted on an edge where cmd_valid&cmd_ready.
REQ-009 cmd_mode  in  2  selector value to apply to the gate.
REQ-010 cmd_a, cmd_b  in  1 each  operands.
REQ-011 A, B  out  1 each  registered operands driven to the downstream xnor_gate.
REQ-012 input_state  out  2  registered selector driven to the gate.
REQ-013 Y  in  1  gate output.
REQ-014 rsp_valid  out  1  response present; rsp_ready  in  1  response consumed.
REQ-015 rsp_y  out  1  captured Y; rsp_err  out  1  captured Y != expected; rsp_pwr_fail  out  1  operation aborted by power loss.
REQ-016 clr_cnt  in  1  synchronous clear of counters.
REQ-017 op_count, err_count  out  CNT_W each  completed responses, responses with rsp_err=1.

Function
REQ-018 FSM states are IDLE, DRIVE and RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE with pwr_good=1.
REQ-020 On accept: A<=cmd_a, B<=cmd_b, input_state<=cmd_mode, settle counter<=SETTLE_CYCLES-1, state->DRIVE.
REQ-021 In DRIVE, the counter decrements each edge; on the edge where it equals 0, capture Y into rsp_y, set rsp_valid, and go to RESP; rsp_valid rises exactly SETTLE_CYCLES edges after the accepting edge.
REQ-022 Expected Y: ~(a^b) when mode==2'b11, otherwise a^b; rsp_err = (captured Y != expected) or (Y is not 0/1 in simulation).
REQ-023 RESP holds rsp_valid, rsp_y, rsp_err and rsp_pwr_fail stable until the edge with rsp_ready=1, then goes to IDLE with rsp_valid=0; no command is accepted in that same cycle.
REQ-024 A, B and input_state SHALL change only on an accepting edge; between operations they hold their last values.
REQ-025 pwr_good=0 during DRIVE: on that edge go to RESP with rsp_valid=1, rsp_pwr_fail=1, rsp_err=1 and rsp_y=0.
REQ-026 pwr_good=0 in IDLE blocks acceptance only; pwr_good=0 in RESP has no effect.
REQ-027 op_count increments on each response handshake; err_count increments when that response has rsp_err=1; both saturate at 2^CNT_W-1.
REQ-028 clr_cnt=1 zeroes both counters; clr_cnt wins over a same-edge increment.

Reset
REQ-029 rst_n low immediately forces IDLE, cmd_ready=0, rsp_valid=0, rsp_y=0, rsp_err=0, rsp_pwr_fail=0, A=0, B=0, input_state=2'b00, settle counter=0, op_count=0, err_count=0.
REQ-030 Reset asserted mid-operation in DRIVE or RESP discards the operation, and no response is produced after release.
REQ-031 After rst_n deasserts, cmd_ready becomes 1 on the first edge at which pwr_good=1.

Structure
REQ-032 Package gate_op_pkg SHALL hold the FSM state enum, the selector encodings (SEL_00..SEL_11) and the expected-output function.
REQ-033 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.

Verification
REQ-034 SETTLE_CYCLES=2, cmd mode=00, a=1, b=0, gate modelled correctly -> rsp_valid 2 edges after accept, rsp_y=1, rsp_err=0, op_count=1.
REQ-035 mode=11, a=1, b=1 -> rsp_y=1, rsp_err=0; mode=11, a=0, b=1 with Y forced to 1 -> rsp_err=1, err_count=1.
REQ-036 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0, and A/B/input_state unchanged; after handshake, next accept occurs no earlier than the following cycle.
REQ-037 VPWR=0 on the first DRIVE cycle -> next edge rsp_valid=1, rsp_pwr_fail=1, rsp_err=1; with VPWR=0 in IDLE -> cmd_ready=0.
REQ-038 CNT_W=2, 5 responses with clr_cnt asserted on the 5th handshake -> counters read 3 after the 4th response and 0 after the 5th.
REQ-039 rst_n pulsed low during DRIVE -> all outputs take reset values asynchronously and no rsp_valid follows.
